// File: rtl/min_receive_fsm.sv
// ---------------------------------------------------------------------------
// min_receive_fsm
//
// Byte-level receiver for MIN-style frames arriving from a UART. It hunts for
// a three-byte 0xAA header, removes stuffing bytes, collects the ID, length
// and payload, checks a CRC32 and the 0x55 end-of-frame marker. A frame that
// passes every check is presented on the o_id/o_len/o_data outputs together
// with a one-cycle o_valid pulse.
//
// Parameters
//   N_DATA_BYTE  maximum payload length the receiver accepts (1..255)
//
// Ports
//   i_clk        clock, every register updates on its rising edge
//   i_rst        synchronous active-high reset
//   i_en         enable; while low, incoming bytes are ignored and state holds
//   i_valid      one-cycle strobe marking a new byte on i_byte
//   i_byte       received UART byte
//   o_valid      one-cycle pulse, a good frame has been delivered
//   o_id         ID/control byte of the last good frame
//   o_len        payload length of the last good frame
//   o_data       payload of the last good frame, first byte most significant
//   o_crc_err    one-cycle pulse, frame dropped because the CRC did not match
//   o_frame_err  one-cycle pulse, frame dropped for bad length or bad EOF byte
//   o_busy       high whenever the receiver is inside a frame
// ---------------------------------------------------------------------------
module min_receive_fsm #(
  parameter int N_DATA_BYTE = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_en,
  input  logic                     i_valid,
  input  logic [7:0]               i_byte,
  output logic                     o_valid,
  output logic [7:0]               o_id,
  output logic [7:0]               o_len,
  output logic [8*N_DATA_BYTE-1:0] o_data,
  output logic                     o_crc_err,
  output logic                     o_frame_err,
  output logic                     o_busy
);

  localparam int          DataWidth  = 8 * N_DATA_BYTE;
  localparam logic [7:0]  HeaderByte = 8'hAA;
  localparam logic [7:0]  StuffByte  = 8'h55;
  localparam logic [7:0]  EofByte    = 8'h55;
  localparam logic [7:0]  MaxLen     = 8'(N_DATA_BYTE);
  localparam logic [31:0] CrcPoly    = 32'hEDB88320;
  localparam logic [31:0] CrcInit    = 32'hFFFFFFFF;

  typedef enum logic [2:0] {
    StHunt,
    StId,
    StLen,
    StPayload,
    StCrc,
    StEof
  } state_t;

  // Registered state
  state_t                 r_state;
  logic [1:0]             r_aaCount;
  logic [31:0]            r_crc;
  logic [31:0]            r_rxCrc;
  logic [DataWidth-1:0]   r_data;
  logic [7:0]             r_byteCount;
  logic [7:0]             r_id;
  logic [7:0]             r_len;
  logic [7:0]             r_outId;
  logic [7:0]             r_outLen;
  logic [DataWidth-1:0]   r_outData;
  logic                   r_outValid;
  logic                   r_crcErr;
  logic                   r_frameErr;

  // Next-state values produced by the combinational process
  state_t                 w_nextState;
  logic [1:0]             w_nextAaCount;
  logic [31:0]            w_nextCrc;
  logic [31:0]            w_nextRxCrc;
  logic [DataWidth-1:0]   w_nextData;
  logic [7:0]             w_nextByteCount;
  logic [7:0]             w_nextId;
  logic [7:0]             w_nextLen;
  logic                   w_goodFrame;
  logic                   w_crcErr;
  logic                   w_frameErr;

  // Helper values
  logic                   w_accept;
  logic                   w_isAa;
  logic                   w_header;
  logic                   w_stuff;
  logic                   w_crcMatch;
  logic [31:0]            w_crcByte;
  logic [DataWidth-1:0]   w_shiftedData;

  // One full byte of the reflected CRC32 in a single cycle: the byte is
  // folded into the low end of the register and eight LSB-first polynomial
  // steps are unrolled.
  function automatic logic [31:0] crcUpdate(input logic [31:0] crcIn,
                                            input logic [7:0]  dataIn);
    logic [31:0] crc;
    crc = crcIn ^ {24'h000000, dataIn};
    for (int k = 0; k < 8; k++) begin
      crc = crc[0] ? ((crc >> 1) ^ CrcPoly) : (crc >> 1);
    end
    return crc;
  endfunction

  // Byte classification. Header detection watches the raw stream in every
  // state, so it is evaluated before any frame-level decision. A 0x55 after
  // exactly two raw 0xAA bytes is a stuffing byte, but only once a frame has
  // started; in HUNT it is just an ordinary byte that breaks the 0xAA run.
  // The CRC stored in the register is the running value before the final
  // inversion, so the received CRC is compared against its complement.
  always_comb begin
    w_accept      = i_en && i_valid;
    w_isAa        = (i_byte == HeaderByte);
    w_header      = w_accept && w_isAa && (r_aaCount == 2'd2);
    w_stuff       = w_accept && !w_isAa && (r_aaCount == 2'd2) &&
                    (i_byte == StuffByte) && (r_state != StHunt);
    w_crcByte     = crcUpdate(r_crc, i_byte);
    w_shiftedData = DataWidth'({r_data, i_byte});
    w_crcMatch    = (r_rxCrc == ~r_crc);
  end

  // Next-state and datapath decisions for one accepted byte. A header wins
  // over everything and silently restarts the frame; a stuffing byte only
  // resets the 0xAA run; any other byte advances the frame state machine.
  // The pulse requests computed here are registered, so every pulse appears
  // in the cycle after the byte that caused it.
  always_comb begin
    w_nextState     = r_state;
    w_nextAaCount   = r_aaCount;
    w_nextCrc       = r_crc;
    w_nextRxCrc     = r_rxCrc;
    w_nextData      = r_data;
    w_nextByteCount = r_byteCount;
    w_nextId        = r_id;
    w_nextLen       = r_len;
    w_goodFrame     = 1'b0;
    w_crcErr        = 1'b0;
    w_frameErr      = 1'b0;

    if (w_header) begin
      w_nextState     = StId;
      w_nextAaCount   = 2'd0;
      w_nextCrc       = CrcInit;
      w_nextRxCrc     = 32'h00000000;
      w_nextData      = '0;
      w_nextByteCount = 8'd0;
    end else if (w_stuff) begin
      w_nextAaCount = 2'd0;
    end else if (w_accept) begin
      w_nextAaCount = w_isAa ? (r_aaCount + 2'd1) : 2'd0;
      unique case (r_state)
        StHunt: begin
          w_nextState = StHunt;
        end
        StId: begin
          w_nextId    = i_byte;
          w_nextCrc   = w_crcByte;
          w_nextState = StLen;
        end
        StLen: begin
          w_nextLen       = i_byte;
          w_nextCrc       = w_crcByte;
          w_nextByteCount = 8'd0;
          if (i_byte > MaxLen) begin
            w_frameErr  = 1'b1;
            w_nextState = StHunt;
          end else if (i_byte == 8'd0) begin
            w_nextState = StCrc;
          end else begin
            w_nextState = StPayload;
          end
        end
        StPayload: begin
          w_nextData = w_shiftedData;
          w_nextCrc  = w_crcByte;
          if (r_byteCount == (r_len - 8'd1)) begin
            w_nextByteCount = 8'd0;
            w_nextState     = StCrc;
          end else begin
            w_nextByteCount = r_byteCount + 8'd1;
          end
        end
        StCrc: begin
          w_nextRxCrc = {r_rxCrc[23:0], i_byte};
          if (r_byteCount == 8'd3) begin
            w_nextByteCount = 8'd0;
            w_nextState     = StEof;
          end else begin
            w_nextByteCount = r_byteCount + 8'd1;
          end
        end
        StEof: begin
          w_nextState = StHunt;
          if (i_byte != EofByte) begin
            w_frameErr = 1'b1;
          end else if (w_crcMatch) begin
            w_goodFrame = 1'b1;
          end else begin
            w_crcErr = 1'b1;
          end
        end
        default: begin
          w_nextState = StHunt;
        end
      endcase
    end
  end

  // Frame state register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= StHunt;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Working registers of the frame in progress: 0xAA run length, running
  // CRC, received CRC, payload shift register, byte counter and the ID and
  // length captured for the current frame.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_aaCount   <= 2'd0;
      r_crc       <= CrcInit;
      r_rxCrc     <= 32'h00000000;
      r_data      <= '0;
      r_byteCount <= 8'd0;
      r_id        <= 8'h00;
      r_len       <= 8'h00;
    end else begin
      r_aaCount   <= w_nextAaCount;
      r_crc       <= w_nextCrc;
      r_rxCrc     <= w_nextRxCrc;
      r_data      <= w_nextData;
      r_byteCount <= w_nextByteCount;
      r_id        <= w_nextId;
      r_len       <= w_nextLen;
    end
  end

  // Delivered-frame registers and status pulses. The frame outputs are
  // loaded only together with o_valid so they keep the last good frame
  // until the next one arrives. The three pulse sources are mutually
  // exclusive because they come from different branches of the EOF/LEN
  // decoding above.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_outId    <= 8'h00;
      r_outLen   <= 8'h00;
      r_outData  <= '0;
      r_outValid <= 1'b0;
      r_crcErr   <= 1'b0;
      r_frameErr <= 1'b0;
    end else begin
      r_outValid <= w_goodFrame;
      r_crcErr   <= w_crcErr;
      r_frameErr <= w_frameErr;
      if (w_goodFrame) begin
        r_outId   <= r_id;
        r_outLen  <= r_len;
        r_outData <= r_data;
      end
    end
  end

  // Output mapping; busy reflects the registered state directly.
  assign o_valid     = r_outValid;
  assign o_id        = r_outId;
  assign o_len       = r_outLen;
  assign o_data      = r_outData;
  assign o_crc_err   = r_crcErr;
  assign o_frame_err = r_frameErr;
  assign o_busy      = (r_state != StHunt);

endmodule

// File: tb/tb_min_receive_fsm.sv
// ---------------------------------------------------------------------------
// tb_min_receive_fsm
//
// Self-checking bench for min_receive_fsm with N_DATA_BYTE = 4. Frames are
// built from (ID, length, payload) with a table-driven CRC32 and a
// transmitter-side stuffing encoder; the expected outcome of each frame is
// queued and compared with the pulses a monitor collects from the DUT.
// ---------------------------------------------------------------------------
module tb_min_receive_fsm;

  localparam int N = 4;

  logic            i_clk;
  logic            i_rst;
  logic            i_en;
  logic            i_valid;
  logic [7:0]      i_byte;
  logic            o_valid;
  logic [7:0]      o_id;
  logic [7:0]      o_len;
  logic [8*N-1:0]  o_data;
  logic            o_crc_err;
  logic            o_frame_err;
  logic            o_busy;

  typedef struct {
    int          kind;
    logic [7:0]  id;
    logic [7:0]  len;
    logic [31:0] data;
  } frameEvent_t;

  localparam int KindValid    = 1;
  localparam int KindCrcErr   = 2;
  localparam int KindFrameErr = 3;

  int          checkCount = 0;
  int          errorCount = 0;
  logic [31:0] crcTable [256];
  logic [7:0]  txQ [$];
  logic [7:0]  payQ [$];
  frameEvent_t obsQ [$];
  frameEvent_t expQ [$];
  int          runCount = 0;
  bit          monitorOn = 1'b0;
  logic        rstAtEdge = 1'b1;
  logic [47:0] prevOut = 48'h0;

  min_receive_fsm #(.N_DATA_BYTE(N)) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_en        (i_en),
    .i_valid     (i_valid),
    .i_byte      (i_byte),
    .o_valid     (o_valid),
    .o_id        (o_id),
    .o_len       (o_len),
    .o_data      (o_data),
    .o_crc_err   (o_crc_err),
    .o_frame_err (o_frame_err),
    .o_busy      (o_busy)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  // Single comparison point: counts and reports every check.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Reflected CRC32 byte step from a precomputed table.
  function automatic logic [31:0] crcStep(input logic [31:0] c, input logic [7:0] b);
    return crcTable[c[7:0] ^ b] ^ (c >> 8);
  endfunction

  function automatic logic [7:0] rndByte();
    return ($urandom_range(0, 3) == 0) ? 8'hAA : 8'($urandom_range(0, 255));
  endfunction

  // Transmitter stuffing: after every two consecutive 0xAA body bytes a 0x55
  // is inserted so the body can never imitate a header.
  task automatic pushBody(input logic [7:0] b);
    txQ.push_back(b);
    runCount = (b == 8'hAA) ? runCount + 1 : 0;
    if (runCount == 2) begin
      txQ.push_back(8'h55);
      runCount = 0;
    end
  endtask

  task automatic pushHeader();
    repeat (3) txQ.push_back(8'hAA);
    runCount = 0;
  endtask

  task automatic setPayload(input logic [31:0] word, input int n);
    payQ.delete();
    for (int j = n - 1; j >= 0; j--) payQ.push_back(word[8*j +: 8]);
  endtask

  // Appends a complete raw frame to txQ. Without a tail only the header, ID
  // and length are sent (used for oversize lengths).
  task automatic buildFrame(input logic [7:0] id, input logic [7:0] lenField,
                            input logic [31:0] crcFlip, input logic [7:0] eofByte,
                            input bit withTail);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    c = crcStep(c, id);
    c = crcStep(c, lenField);
    foreach (payQ[j]) c = crcStep(c, payQ[j]);
    c = ~c ^ crcFlip;
    pushHeader();
    pushBody(id);
    pushBody(lenField);
    if (withTail) begin
      foreach (payQ[j]) pushBody(payQ[j]);
      pushBody(c[31:24]);
      pushBody(c[23:16]);
      pushBody(c[15:8]);
      pushBody(c[7:0]);
      txQ.push_back(eofByte);
    end
  endtask

  task automatic expectEvent(input int kind, input logic [7:0] id,
                             input logic [7:0] len, input logic [31:0] data);
    frameEvent_t ev;
    ev.kind = kind;
    ev.id   = id;
    ev.len  = len;
    ev.data = data;
    expQ.push_back(ev);
  endtask

  task automatic applyStimulus(input logic [7:0] b);
    i_en    = 1'b1;
    i_valid = 1'b1;
    i_byte  = b;
    @(posedge i_clk);
    #1;
    i_valid = 1'b0;
  endtask

  task automatic idleCycles(input int n);
    i_valid = 1'b0;
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  task automatic enLowGarbage(input logic [7:0] b);
    i_en    = 1'b0;
    i_valid = 1'b1;
    i_byte  = b;
    @(posedge i_clk);
    #1;
    i_valid = 1'b0;
    i_en    = 1'b1;
  endtask

  task automatic pulseReset();
    i_rst = 1'b1;
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;
  endtask

  // Sends txQ; optional random idle/en-low gaps, optional fixed en-low burst
  // (including a fake header) before byte index burstAt.
  task automatic sendTx(input int gapMode, input int burstAt);
    for (int i = 0; i < txQ.size(); i++) begin
      if (i == burstAt) begin
        enLowGarbage(8'hAA);
        enLowGarbage(8'hAA);
        enLowGarbage(8'hAA);
        enLowGarbage(8'h55);
        enLowGarbage(8'h13);
      end
      if (gapMode != 0) begin
        case ($urandom_range(0, 7))
          0: idleCycles($urandom_range(1, 2));
          1: enLowGarbage(rndByte());
          default: ;
        endcase
      end
      applyStimulus(txQ[i]);
    end
    txQ.delete();
  endtask

  task automatic checkEvents(input string tag);
    checkOutput({tag, "_count"}, 64'(obsQ.size()), 64'(expQ.size()));
    for (int i = 0; i < obsQ.size() && i < expQ.size(); i++) begin
      checkOutput({tag, "_kind"}, 64'(obsQ[i].kind), 64'(expQ[i].kind));
      if (expQ[i].kind == KindValid) begin
        checkOutput({tag, "_id"},   64'(obsQ[i].id),   64'(expQ[i].id));
        checkOutput({tag, "_len"},  64'(obsQ[i].len),  64'(expQ[i].len));
        checkOutput({tag, "_data"}, 64'(obsQ[i].data), 64'(expQ[i].data));
      end
    end
    obsQ.delete();
    expQ.delete();
  endtask

  // Remembers whether the last active edge was a reset edge.
  always @(posedge i_clk) rstAtEdge <= i_rst;

  // Monitor: collects pulses, checks that at most one pulse is high and that
  // the frame outputs only move together with o_valid.
  always @(negedge i_clk) begin
    int pulses;
    frameEvent_t ev;
    if (monitorOn) begin
      pulses = int'(o_valid) + int'(o_crc_err) + int'(o_frame_err);
      if (pulses != 0) checkOutput("onePulse", 64'(pulses), 64'd1);
      if (!rstAtEdge && !o_valid && ({o_id, o_len, o_data} !== prevOut))
        checkOutput("holdOutputs", 64'({o_id, o_len, o_data}), 64'(prevOut));
      prevOut = {o_id, o_len, o_data};
      ev.id   = o_id;
      ev.len  = o_len;
      ev.data = o_data;
      if (o_valid)     begin ev.kind = KindValid;    obsQ.push_back(ev); end
      if (o_crc_err)   begin ev.kind = KindCrcErr;   obsQ.push_back(ev); end
      if (o_frame_err) begin ev.kind = KindFrameErr; obsQ.push_back(ev); end
    end
  end

  initial begin
    logic [7:0]  rid;
    logic [7:0]  rb;
    logic [31:0] rdata;
    int          mode;
    int          rlen;

    for (int i = 0; i < 256; i++) begin
      logic [31:0] c;
      c = 32'(i);
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      crcTable[i] = c;
    end

    // Reset with enable and a would-be header on the inputs: reset wins.
    i_rst   = 1'b1;
    i_en    = 1'b1;
    i_valid = 1'b1;
    i_byte  = 8'hAA;
    repeat (4) @(posedge i_clk);
    #1;
    i_valid = 1'b0;
    i_rst   = 1'b0;
    checkOutput("rstBusy",     64'(o_busy),      64'd0);
    checkOutput("rstValid",    64'(o_valid),     64'd0);
    checkOutput("rstCrcErr",   64'(o_crc_err),   64'd0);
    checkOutput("rstFrameErr", 64'(o_frame_err), 64'd0);
    checkOutput("rstId",       64'(o_id),        64'd0);
    checkOutput("rstLen",      64'(o_len),       64'd0);
    checkOutput("rstData",     64'(o_data),      64'd0);
    monitorOn = 1'b1;

    // Good frame, latency of one cycle after EOF.
    setPayload(32'h12345678, 4);
    buildFrame(8'h80, 8'd4, 32'h0, 8'h55, 1'b1);
    expectEvent(KindValid, 8'h80, 8'd4, 32'h12345678);
    sendTx(0, -1);
    checkOutput("goodLatency", 64'(o_valid), 64'd1);
    checkOutput("goodData",    64'(o_data),  64'h12345678);
    idleCycles(3);
    checkEvents("good");

    // Stuffed payload AA AA 00 01 goes out as AA AA 55 00 01.
    setPayload(32'hAAAA0001, 4);
    buildFrame(8'h80, 8'd4, 32'h0, 8'h55, 1'b1);
    expectEvent(KindValid, 8'h80, 8'd4, 32'hAAAA0001);
    sendTx(0, -1);
    idleCycles(3);
    checkEvents("stuff");

    // One CRC bit flipped.
    setPayload(32'h12345678, 4);
    buildFrame(8'h80, 8'd4, 32'h1 << $urandom_range(0, 31), 8'h55, 1'b1);
    expectEvent(KindCrcErr, 8'h0, 8'h0, 32'h0);
    sendTx(0, -1);
    idleCycles(3);
    checkEvents("crcFlip");

    // Bad EOF byte.
    buildFrame(8'h80, 8'd4, 32'h0, 8'h54, 1'b1);
    expectEvent(KindFrameErr, 8'h0, 8'h0, 32'h0);
    sendTx(0, -1);
    idleCycles(3);
    checkEvents("badEof");

    // Oversize length: error right after the LEN byte.
    payQ.delete();
    buildFrame(8'h80, 8'd5, 32'h0, 8'h55, 1'b0);
    expectEvent(KindFrameErr, 8'h0, 8'h0, 32'h0);
    sendTx(0, -1);
    checkOutput("lenErrPulse", 64'(o_frame_err), 64'd1);
    checkOutput("lenErrBusy",  64'(o_busy),      64'd0);
    idleCycles(3);
    checkEvents("lenErr");

    // Resync: header injected after two payload bytes, then a LEN=2 frame.
    pushHeader();
    pushBody(8'h80);
    pushBody(8'h04);
    pushBody(8'h12);
    pushBody(8'h34);
    setPayload(32'h0000BEEF, 2);
    buildFrame(8'h80, 8'd2, 32'h0, 8'h55, 1'b1);
    expectEvent(KindValid, 8'h80, 8'd2, 32'h0000BEEF);
    sendTx(0, -1);
    idleCycles(3);
    checkEvents("resync");

    // Reset mid-payload clears outputs and drops the frame silently.
    pushHeader();
    pushBody(8'h80);
    pushBody(8'h04);
    pushBody(8'h12);
    pushBody(8'h34);
    sendTx(0, -1);
    checkOutput("midBusy", 64'(o_busy), 64'd1);
    pulseReset();
    checkOutput("rstMidBusy", 64'(o_busy), 64'd0);
    checkOutput("rstMidId",   64'(o_id),   64'd0);
    checkOutput("rstMidData", 64'(o_data), 64'd0);
    applyStimulus(8'h56);
    applyStimulus(8'h78);
    idleCycles(3);
    checkEvents("rstMid");

    // Enable held low for a burst (including a fake header) mid-frame.
    setPayload(32'h00010203, 3);
    buildFrame(8'h3C, 8'd3, 32'h0, 8'h55, 1'b1);
    expectEvent(KindValid, 8'h3C, 8'd3, 32'h00010203);
    sendTx(0, 6);
    idleCycles(3);
    checkEvents("enLow");

    // Zero-length frame.
    payQ.delete();
    buildFrame(8'hAA, 8'd0, 32'h0, 8'h55, 1'b1);
    expectEvent(KindValid, 8'hAA, 8'd0, 32'h0);
    sendTx(0, -1);
    idleCycles(3);
    checkEvents("zeroLen");

    // Randomized back-to-back frames with mixed outcomes and gaps.
    for (int f = 0; f < 60; f++) begin
      mode  = $urandom_range(0, 3);
      rid   = rndByte();
      rlen  = $urandom_range(0, N);
      rdata = 32'h0;
      payQ.delete();
      for (int j = 0; j < rlen; j++) begin
        rb = rndByte();
        payQ.push_back(rb);
        rdata = (rdata << 8) | 32'(rb);
      end
      case (mode)
        0: begin
          buildFrame(rid, 8'(rlen), 32'h0, 8'h55, 1'b1);
          expectEvent(KindValid, rid, 8'(rlen), rdata);
        end
        1: begin
          buildFrame(rid, 8'(rlen), 32'h1 << $urandom_range(0, 31), 8'h55, 1'b1);
          expectEvent(KindCrcErr, 8'h0, 8'h0, 32'h0);
        end
        2: begin
          do rb = 8'($urandom_range(0, 255)); while (rb == 8'h55 || rb == 8'hAA);
          buildFrame(rid, 8'(rlen), 32'h0, rb, 1'b1);
          expectEvent(KindFrameErr, 8'h0, 8'h0, 32'h0);
        end
        default: begin
          do rb = 8'($urandom_range(N + 1, 255)); while (rb == 8'hAA);
          payQ.delete();
          buildFrame(rid, rb, 32'h0, 8'h55, 1'b0);
          expectEvent(KindFrameErr, 8'h0, 8'h0, 32'h0);
        end
      endcase
      sendTx(int'($urandom_range(0, 1)), -1);
    end
    idleCycles(4);
    checkEvents("random");

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/min_receive_fsm.md
MIN_RECEIVE_FSM -- requirements
Module: min_receive_fsm

Interface
REQ-001 Parameter N_DATA_BYTE, default 4: maximum accepted payload length in bytes (1..255).
REQ-002 i_clk  input  1  single clock; all logic on its rising edge.
REQ-003 i_rst  input  1  reset, synchronous and active-high.
REQ-004 i_en  input  1  enable; when low, i_valid is ignored and all state holds.
REQ-005 i_valid  input  1  one-cycle strobe: i_byte holds a received UART byte.
REQ-006 i_byte  input  8  received byte.
REQ-007 o_valid  output  1  one-cycle pulse: good frame delivered.
REQ-008 o_id  output  8  ID/control byte of the last good frame, passed through unchanged (bit 7 included).
REQ-009 o_len  output  8  payload length of the last good frame.
REQ-010 o_data  output  8*N_DATA_BYTE  payload of the last good frame.
REQ-011 o_crc_err  output  1  one-cycle pulse: frame dropped, CRC mismatch.
REQ-012 o_frame_err  output  1  one-cycle pulse: frame dropped, length > N_DATA_BYTE or bad EOF byte.
REQ-013 o_busy  output  1  high whenever state is not HUNT.

Function
REQ-014 Frame format: header 0xAA 0xAA 0xAA, ID, LEN, LEN payload bytes, CRC32 (4 bytes, MSB first), EOF 0x55. The block accepts one byte per i_valid&&i_en cycle.
REQ-015 States: HUNT, ID, LEN, PAYLOAD, CRC, EOF.
REQ-016 Header detection runs in every state: three consecutive raw 0xAA bytes force state ID, clear the CRC, the payload shift register and the counters, and abort any frame in progress. The aborted frame is dropped silently, with no error pulse.
REQ-017 Destuffing applies outside HUNT: a byte that follows exactly two consecutive raw 0xAA bytes and equals 0x55 is discarded. It does not advance state and does not update the CRC. The raw-0xAA run counter then resets to 0.
REQ-018 ID: store the byte and go to LEN.
REQ-019 LEN: store the byte. If LEN > N_DATA_BYTE, pulse o_frame_err on the next cycle and go to HUNT. If LEN = 0, go to CRC. Otherwise go to PAYLOAD.
REQ-020 PAYLOAD: shift register <= {reg[8*N_DATA_BYTE-9:0], byte}, so the first byte ends at bits [8*LEN-1:8*LEN-8] and the upper bits are 0. After LEN bytes, go to CRC.
REQ-021 CRC32 covers ID, LEN and payload (post-destuffing).
- Reflected polynomial 0xEDB88320, init 0xFFFFFFFF, final XOR 0xFFFFFFFF.
- Updated one full byte per accepted byte, in one cycle.
REQ-022 CRC: shift in 4 bytes MSB first, then go to EOF.
REQ-023 EOF outcomes; the state returns to HUNT in every case:
- byte is 0x55 and CRC matches: load o_id, o_len, o_data and pulse o_valid on the next cycle (latency 1 cycle from EOF acceptance);
- byte is 0x55 and CRC differs: pulse o_crc_err instead;
- byte is not 0x55: pulse o_frame_err instead.
REQ-024 o_id, o_len and o_data change only together with an o_valid pulse and hold their values otherwise.
REQ-025 At most one of o_valid, o_crc_err and o_frame_err is high in any cycle.
REQ-026 Back-to-back frames: bytes on consecutive cycles are accepted with no dead cycle. A header arriving immediately after EOF is detected.

Reset
REQ-027 When i_rst is high on a clock edge:
- state becomes HUNT and all counters, the CRC and the shift register clear;
- o_valid, o_crc_err, o_frame_err and o_busy become 0;
- o_id, o_len and o_data become 0.
REQ-028 Reset takes precedence over i_en and i_valid. Reset mid-frame drops the frame with no pulse.

Verification
REQ-029 Good frame: N_DATA_BYTE=4, frame ID 0x80, LEN 0x04, payload 12 34 56 78, correct CRC from the bench model, EOF 0x55. Required: one o_valid pulse with o_id=0x80, o_len=4, o_data=0x12345678, and no error pulse.
REQ-030 Stuffing: payload AA AA 00 01 sent as AA AA 55 00 01 with correct CRC. Required: o_valid with o_data=0xAAAA0001.
REQ-031 Errors: the REQ-029 frame with one CRC bit flipped gives a single o_crc_err pulse. The same frame with EOF 0x54 gives o_frame_err. LEN 0x05 gives o_frame_err right after the LEN byte. None of the three produces o_valid.
REQ-032 Resync and short frame:
- AA AA AA injected after the second payload byte, then a complete good LEN=2 frame (0xBEEF);
- required: a single o_valid with o_data=0x0000BEEF and no error pulse.
REQ-033 Control:
- i_rst pulsed mid-payload: o_busy=0 next cycle and no pulse for the interrupted frame;
- i_en held low during a frame: bytes with i_valid are ignored;
- the frame completes correctly once i_en returns high.
